// File: rtl/choice_game_fsm.sv
// rtl/choice_game_fsm.sv - staged push-button choice game controller; optional GAME_TIMEOUT_EN auto-commit
module choice_game_fsm #(
    parameter int NUM_BUTTONS     = 4,
    parameter int NUM_STAGES      = 4,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int TIMEOUT_CYCLES  = 1000,
    localparam int IDX_W = (NUM_BUTTONS > 2) ? $clog2(NUM_BUTTONS) : 1,
    localparam int STG_W = (NUM_STAGES > 2) ? $clog2(NUM_STAGES) : 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_BUTTONS-1:0]      buttons,
    output logic [1:0]                  state,
    output logic [STG_W-1:0]            stage,
    output logic                        choice_valid,
    output logic [IDX_W-1:0]            choice_idx,
    output logic [NUM_STAGES*IDX_W-1:0] history,
    output logic                        done,
    output logic                        timeout
);

    localparam int DB_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;

    if (NUM_BUTTONS < 2 || NUM_BUTTONS > 16 || NUM_STAGES < 1 || NUM_STAGES > 16 ||
        DEBOUNCE_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("choice_game_fsm: parameter out of range");
    end

    typedef enum logic [1:0] {S_IDLE, S_CHOOSE, S_CONFIRM, S_END} state_t;

    logic [NUM_BUTTONS-1:0] sync1, sync2, clean;
    logic [DB_W-1:0]        db_cnt;

    // Counter restarts whenever sync2 is about to change, so only a steady differing level is accepted
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1  <= '0;
            sync2  <= '0;
            clean  <= '0;
            db_cnt <= '0;
        end else begin
            sync1 <= buttons;
            sync2 <= sync1;
            if (sync2 == clean || sync1 != sync2) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                clean  <= sync2;
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + DB_W'(1);
            end
        end
    end

    logic             press, release_all;
    logic [IDX_W-1:0] press_idx;

    always_comb begin
        press_idx = '0;
        for (int i = 0; i < NUM_BUTTONS; i++) begin
            if (clean[i]) press_idx = IDX_W'(i);
        end
    end

    assign press       = $onehot(clean);
    assign release_all = (clean == '0);

    state_t                      cur, nxt, ret, ret_nxt;
    logic [IDX_W-1:0]            pend, pend_nxt, idx_nxt, commit_val;
    logic [STG_W-1:0]            stage_nxt;
    logic [NUM_STAGES*IDX_W-1:0] hist_nxt;
    logic                        commit, to_fire;

`ifdef GAME_TIMEOUT_EN
    localparam int TO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [TO_W-1:0] to_cnt, to_cnt_nxt;
`endif

    always_comb begin
        nxt        = cur;
        ret_nxt    = ret;
        pend_nxt   = pend;
        stage_nxt  = stage;
        hist_nxt   = history;
        idx_nxt    = choice_idx;
        commit     = 1'b0;
        commit_val = pend;
        to_fire    = 1'b0;
        case (cur)
            S_IDLE: begin
                if (press) begin
                    ret_nxt = S_IDLE;
                    nxt     = S_CONFIRM;
                end
            end
            S_CHOOSE: begin
                if (press) begin
                    pend_nxt = press_idx;
                    ret_nxt  = S_CHOOSE;
                    nxt      = S_CONFIRM;
                end
`ifdef GAME_TIMEOUT_EN
                else if (to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
                    commit     = 1'b1;
                    commit_val = '0;
                    to_fire    = 1'b1;
                end
`endif
            end
            S_CONFIRM: begin
                if (release_all) begin
                    case (ret)
                        S_IDLE: begin
                            hist_nxt  = '0;
                            stage_nxt = '0;
                            nxt       = S_CHOOSE;
                        end
                        S_CHOOSE: commit = 1'b1;
                        default:  nxt = S_IDLE;
                    endcase
                end
            end
            default: begin
                if (press) begin
                    ret_nxt = S_END;
                    nxt     = S_CONFIRM;
                end
            end
        endcase
        if (commit) begin
            hist_nxt[int'(stage)*IDX_W +: IDX_W] = commit_val;
            idx_nxt = commit_val;
            if (stage == STG_W'(NUM_STAGES - 1)) begin
                nxt = S_END;
            end else begin
                stage_nxt = stage + STG_W'(1);
                nxt       = S_CHOOSE;
            end
        end
`ifdef GAME_TIMEOUT_EN
        to_cnt_nxt = (cur == S_CHOOSE && nxt == S_CHOOSE && !commit) ? to_cnt + TO_W'(1) : '0;
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cur          <= S_IDLE;
            ret          <= S_IDLE;
            pend         <= '0;
            stage        <= '0;
            history      <= '0;
            choice_idx   <= '0;
            choice_valid <= 1'b0;
            done         <= 1'b0;
        end else begin
            cur          <= nxt;
            ret          <= ret_nxt;
            pend         <= pend_nxt;
            stage        <= stage_nxt;
            history      <= hist_nxt;
            choice_idx   <= idx_nxt;
            choice_valid <= commit;
            done         <= (nxt == S_END);
        end
    end

`ifdef GAME_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            to_cnt  <= '0;
            timeout <= 1'b0;
        end else begin
            to_cnt  <= to_cnt_nxt;
            timeout <= to_fire;
        end
    end
`else
    logic unused_to;
    assign unused_to = to_fire;
    assign timeout   = 1'b0;
`endif

    assign state = cur;

endmodule

// File: tb/tb_choice_game_fsm.sv
// tb/tb_choice_game_fsm.sv - directed self-checking bench for choice_game_fsm
module tb_choice_game_fsm;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] buttons;
    logic [1:0] state;
    logic [1:0] stage;
    logic       choice_valid;
    logic [1:0] choice_idx;
    logic [7:0] history;
    logic       done;
    logic       timeout;

    int n_tests = 0;
    int n_fail  = 0;
    int vcnt    = 0;
    int to_cnt  = 0;
    logic [1:0] last_idx = '0;
    logic       last_to  = 1'b0;
    int v0;

    choice_game_fsm #(
        .NUM_BUTTONS    (4),
        .NUM_STAGES     (4),
        .DEBOUNCE_CYCLES(4),
        .TIMEOUT_CYCLES (50)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .buttons     (buttons),
        .state       (state),
        .stage       (stage),
        .choice_valid(choice_valid),
        .choice_idx  (choice_idx),
        .history     (history),
        .done        (done),
        .timeout     (timeout)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (choice_valid) begin
            vcnt++;
            last_idx = choice_idx;
            last_to  = timeout;
        end
        if (timeout) to_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_state(input logic [1:0] s, input int budget, input string tag);
        for (int i = 0; i < budget && state !== s; i++) tick(1);
        check(tag, 32'(state), 32'(s));
    endtask

    task automatic press_release(input int b, input string tag);
        buttons = 4'(1 << b);
        wait_state(2'd2, 30, {tag, "_press"});
        buttons = 4'b0000;
        for (int i = 0; i < 30 && state === 2'd2; i++) tick(1);
        check({tag, "_release"}, 32'(state !== 2'd2), 32'd1);
        tick(1);
    endtask

    initial begin
        logic [1:0] seq [4];
        seq = '{2'd2, 2'd1, 2'd3, 2'd0};
        rst     = 1'b0;
        buttons = 4'b0000;
        tick(3);
        check("rst_state", 32'(state), 32'd0);
        check("rst_stage", 32'(stage), 32'd0);
        check("rst_history", 32'(history), 32'd0);
        check("rst_idx", 32'(choice_idx), 32'd0);
        check("rst_valid", 32'(choice_valid), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_timeout", 32'(timeout), 32'd0);

        // raw edge -> clean after 6 edges, FSM moves on the 7th
        rst     = 1'b1;
        buttons = 4'b0001;
        tick(6);
        check("lat_pre", 32'(state), 32'd0);
        tick(1);
        check("lat_post", 32'(state), 32'd2);
        buttons = 4'b0000;
        wait_state(2'd1, 30, "start_choose");
        check("start_stage", 32'(stage), 32'd0);

        for (int k = 0; k < 4; k++) begin
            v0 = vcnt;
            press_release(int'(seq[k]), "game");
            check("game_pulse", 32'(vcnt - v0), 32'd1);
            check("game_idx", 32'(last_idx), 32'(seq[k]));
        end
        check("end_state", 32'(state), 32'd3);
        check("end_done", 32'(done), 32'd1);
        check("end_history", 32'(history), 32'h36);
        check("end_stage", 32'(stage), 32'd3);

        press_release(2, "ack");
        check("ack_state", 32'(state), 32'd0);
        check("ack_history", 32'(history), 32'h36);
        check("ack_stage", 32'(stage), 32'd3);
        check("ack_done", 32'(done), 32'd0);

        buttons = 4'b0010;
        wait_state(2'd2, 30, "g2_press");
        buttons = 4'b0000;
        wait_state(2'd1, 30, "g2_choose");
        check("g2_history_clr", 32'(history), 32'd0);

        v0 = vcnt;
        for (int i = 0; i < 10; i++) begin
            buttons[1] = ~buttons[1];
            tick(2);
        end
        buttons = 4'b0000;
        tick(20);
        check("bounce_state", 32'(state), 32'd1);
        check("bounce_pulse", 32'(vcnt - v0), 32'd0);

        buttons = 4'b0110;
        tick(50);
        check("multi_state", 32'(state), 32'd1);
        check("multi_pulse", 32'(vcnt - v0), 32'd0);
        buttons = 4'b0010;
        wait_state(2'd2, 20, "multi_single");
        buttons = 4'b0000;
        wait_state(2'd1, 30, "multi_commit");
        tick(1);
        check("multi_pulse2", 32'(vcnt - v0), 32'd1);
        check("multi_idx", 32'(last_idx), 32'd1);
        check("multi_stage", 32'(stage), 32'd1);

        v0 = vcnt;
        buttons = 4'b1000;
        tick(100);
        check("hold_state", 32'(state), 32'd2);
        check("hold_pulse", 32'(vcnt - v0), 32'd0);
        buttons = 4'b0000;
        wait_state(2'd1, 30, "hold_commit");
        tick(20);
        check("hold_pulse2", 32'(vcnt - v0), 32'd1);
        check("hold_idx", 32'(last_idx), 32'd3);
        check("hold_stage", 32'(stage), 32'd2);
        check("hold_history", 32'(history), 32'h0d);

        buttons = 4'b0100;
        wait_state(2'd2, 30, "mid_confirm");
        #3;
        rst = 1'b0;
        #1;
        check("mid_state", 32'(state), 32'd0);
        check("mid_stage", 32'(stage), 32'd0);
        check("mid_history", 32'(history), 32'd0);
        check("mid_idx", 32'(choice_idx), 32'd0);
        check("mid_done", 32'(done), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        tick(6);
        check("post_rst_pre", 32'(state), 32'd0);
        tick(1);
        check("post_rst_press", 32'(state), 32'd2);
        buttons = 4'b0000;
        wait_state(2'd1, 30, "to_choose");

        v0 = vcnt;
`ifdef GAME_TIMEOUT_EN
        for (int i = 0; i < 70 && vcnt == v0; i++) tick(1);
        check("to_pulse", 32'(vcnt - v0), 32'd1);
        check("to_flag", 32'(last_to), 32'd1);
        check("to_idx", 32'(last_idx), 32'd0);
        check("to_stage", 32'(stage), 32'd1);
        check("to_count", 32'(to_cnt), 32'd1);
`else
        tick(60);
        check("no_to_state", 32'(state), 32'd1);
        check("no_to_pulse", 32'(vcnt - v0), 32'd0);
        check("no_to_flag", 32'(to_cnt), 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/choice_game_fsm.md
# choice_game_fsm

Parametrised successor to the team's four-choice game controller: walks a player through `NUM_STAGES` sequential choices made on `NUM_BUTTONS` push-buttons. Each choice is taken on a debounced press and committed on release. Committed choices are recorded in a history bus, and the block returns to idle after an end-of-game acknowledge. It sits between the board push-button inputs and the display/scoring logic.

## Interface
- `NUM_BUTTONS`, 4: number of choice buttons, 2..16.
- `NUM_STAGES`, 4: number of choices per game, 1..16.
- `DEBOUNCE_CYCLES`, 16: consecutive stable cycles required before a button change is accepted, ≥1.
- `TIMEOUT_CYCLES`, 1000: per-stage choice timeout; only used with `GAME_TIMEOUT_EN`.
- Derived widths: `IDX_W` = max(1, clog2(`NUM_BUTTONS`)); `STG_W` = max(1, clog2(`NUM_STAGES`)).

Ports:
- `clk` in 1: single system clock.
- `rst` in 1: asynchronous, active-low reset.
- `buttons` in `NUM_BUTTONS`: raw button levels, active-high, asynchronous to `clk`.
- `state` out 2: current state, IDLE=0, CHOOSE=1, CONFIRM=2, END=3.
- `stage` out `STG_W`: index of the current or most recent stage.
- `choice_valid` out 1: one-cycle pulse when a choice is committed.
- `choice_idx` out `IDX_W`: index of the committed choice; valid with `choice_valid`, held after.
- `history` out `NUM_STAGES`*`IDX_W`: choice for stage i at bits [i*`IDX_W` +: `IDX_W`].
- `done` out 1: high while in END.
- `timeout` out 1: one-cycle pulse on an auto-committed choice; constant 0 without the macro.

## Operation
- Input path:
  - A 2-flop synchroniser per button.
  - A shared debouncer: the clean vector takes the synchronised vector once it has differed from clean and stayed constant for `DEBOUNCE_CYCLES` cycles.
  - "Press" means exactly one clean bit is high. "Release" means all clean bits are low.
  - Two or more bits high is ignored: no transition, no latch.
- Return state register `ret` (IDLE, CHOOSE or END) records which state entered CONFIRM.
- IDLE: on press, set `ret`=IDLE and go to CONFIRM.
- CHOOSE:
  - On press, latch the button index into `pend` and set `ret`=CHOOSE; go to CONFIRM.
  - Otherwise stay in CHOOSE.
- CONFIRM: wait for release, then act on `ret`:
  - `ret`=IDLE: clear `history` and set `stage`=0; go to CHOOSE.
  - `ret`=CHOOSE:
    - Write `pend` into `history[stage]`; drive `choice_idx`=`pend`; pulse `choice_valid`.
    - If `stage`==`NUM_STAGES`-1, go to END with `stage` held.
    - Otherwise increment `stage` and go to CHOOSE.
  - `ret`=END: go to IDLE. `history` and `stage` are held until the next game starts.
- END: on press, set `ret`=END and go to CONFIRM.
- Holding a button across a commit never registers a second choice, because CONFIRM requires release.
- Reset values: `state`=IDLE, `stage`=0, `history`=0, `choice_idx`=0, `choice_valid`=0, `done`=0, `timeout`=0.
- Internal reset values: synchroniser flops, clean vector and debounce counter are 0, so no press is seen at reset.
- Reset asserted mid-game forces all of the above immediately, regardless of `buttons`.

## Timing
- A raw button edge reaches the clean vector 2 + `DEBOUNCE_CYCLES` cycles later, provided the input holds.
- The FSM transitions on the first edge after the clean vector shows a press or release.
- `choice_valid`, the `history` update and the `stage` increment all occur on the same edge as the CONFIRM→CHOOSE or CONFIRM→END transition.
- `done` is registered and follows `state`.
- If a press and a timeout expiry coincide, the press wins.

## Configuration
- `GAME_TIMEOUT_EN` defined:
  - A counter runs while in CHOOSE. It resets on entry to CHOOSE and on any commit.
  - When it reaches `TIMEOUT_CYCLES`-1 with no press, choice 0 is committed directly from CHOOSE, exactly as a CONFIRM commit would be.
  - `timeout` pulses on the same cycle as `choice_valid`.
- `GAME_TIMEOUT_EN` undefined: no counter is built, `timeout` is tied to 0, and CHOOSE waits indefinitely.

## Test plan
All scenarios use `NUM_BUTTONS`=4, `NUM_STAGES`=4 and `DEBOUNCE_CYCLES`=4.
- Full game: start on button 0, then press/release 2,1,3,0.
  - Four `choice_valid` pulses with `choice_idx` 2,1,3,0.
  - `history`=8'b00_11_01_10, `done`=1, `stage`=3.
  - Button press/release then returns to IDLE with `history` held.
- Bounce: in CHOOSE, toggle button 1 every 2 cycles for 20 cycles, then release.
  - No state change and no `choice_valid`.
- Multi-press: in CHOOSE, hold buttons 1 and 2 together for 50 cycles.
  - `state` stays 1; `pend` is not latched.
  - Releasing button 2 alone for 10+ cycles then registers a press of 1.
- Hold across commit: hold button 3 for 100 cycles in CHOOSE.
  - `state` stays 2 and no `choice_valid` until release.
  - Exactly one commit follows.
- Reset mid-game: assert `rst`=0 in stage 2 CONFIRM.
  - All outputs reach their reset values asynchronously.
  - A button held through deassertion causes no press until debounce completes.
- `GAME_TIMEOUT_EN`, `TIMEOUT_CYCLES`=50: idle 50 cycles in CHOOSE at stage 0.
  - `choice_valid` and `timeout` pulse together with `choice_idx`=0; `stage`=1.
